// File: rtl/goertzel_bank.sv
// goertzel_bank: NB-bin Goertzel DFT over N-sample frames, one shared cos multiplier time-multiplexed across bins.
// Ports: sample valid/ready in (i_sample*), coefficient write port (i_coef_*, o_coef_err), result valid/ready out (o_res_*).
// Optional GOERTZEL_MAG_EN adds o_res_mag = re^2 + im^2 registered with re/im.
module goertzel_bank #(
  parameter int IW = 12,
  parameter int OW = 32,
  parameter int N  = 126,
  parameter int NB = 4,
  parameter int CW = 16,
  localparam int AW  = (NB > 1) ? $clog2(NB) : 1,
  localparam int NCW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_sample_valid,
  output logic          o_sample_ready,
  input  logic [IW-1:0] i_sample,
  input  logic          i_coef_we,
  input  logic [AW-1:0] i_coef_addr,
  input  logic [CW-1:0] i_coef_cos,
  input  logic [CW-1:0] i_coef_sin,
  output logic          o_coef_err,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [AW-1:0] o_res_bin,
  output logic          o_res_last,
  output logic [OW-1:0] o_res_re,
  output logic [OW-1:0] o_res_im
`ifdef GOERTZEL_MAG_EN
  ,
  output logic [2*OW-1:0] o_res_mag
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, CALC, PRESENT} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]  cos_q [NB];
  logic [CW-1:0]  sin_q [NB];
  logic [OW-1:0]  s1_q  [NB];
  logic [OW-1:0]  s2_q  [NB];
  logic [NCW-1:0] n_q;
  logic [AW-1:0]  b_q;
  logic [IW-1:0]  x_q;
  logic [AW-1:0]  bin_q;
  logic           last_q;
  logic [OW-1:0]  re_q, im_q;
  logic           coef_err_q;

  logic b_last, n_last, coef_ok;
  assign b_last  = (b_q == AW'(NB - 1));
  assign n_last  = (n_q == NCW'(N - 1));
  // Writes only land between frames so a frame never mixes coefficient sets.
  assign coef_ok = i_coef_we && (state_q == IDLE) && (n_q == '0) &&
                   ({1'b0, i_coef_addr} < (AW+1)'(NB));

  // Operands sign-extended to the full product width so the unsigned multiply
  // yields the exact two's-complement product.
  logic [OW+CW-1:0] cos_ext, sin_ext, s1_ext, prod_c, prod_s;
  assign cos_ext = {{OW{cos_q[b_q][CW-1]}}, cos_q[b_q]};
  assign sin_ext = {{OW{sin_q[b_q][CW-1]}}, sin_q[b_q]};
  assign s1_ext  = {{CW{s1_q[b_q][OW-1]}}, s1_q[b_q]};
  assign prod_c  = cos_ext * s1_ext;
  assign prod_s  = sin_ext * s1_ext;

  // Slicing at CW-3 doubles the coefficient (2cos); at CW-2 it is plain cos/sin.
  logic [OW-1:0] s0, calc_re, calc_im;
  assign s0      = {{(OW-IW){x_q[IW-1]}}, x_q} + prod_c[CW-3 +: OW] - s2_q[b_q];
  assign calc_re = prod_c[CW-2 +: OW] - s2_q[b_q];
  assign calc_im = prod_s[CW-2 +: OW];

  logic unused_bits;
  assign unused_bits = ^{prod_c, prod_s};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_sample_valid) state_d = ACCUM;
      ACCUM:   if (b_last) state_d = n_last ? CALC : IDLE;
      CALC:    state_d = PRESENT;
      PRESENT: if (i_res_ready) state_d = b_last ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
    if (i_clr) state_d = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NB; i++) begin
        cos_q[i] <= '0;
        sin_q[i] <= '0;
        s1_q[i]  <= '0;
        s2_q[i]  <= '0;
      end
      n_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      bin_q      <= '0;
      last_q     <= 1'b0;
      re_q       <= '0;
      im_q       <= '0;
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= i_coef_we && !coef_ok;
      if (coef_ok) begin
        cos_q[i_coef_addr] <= i_coef_cos;
        sin_q[i_coef_addr] <= i_coef_sin;
      end
      if (i_clr) begin
        n_q <= '0;
        b_q <= '0;
        for (int i = 0; i < NB; i++) begin
          s1_q[i] <= '0;
          s2_q[i] <= '0;
        end
      end else begin
        unique case (state_q)
          IDLE: if (i_sample_valid) begin
            x_q <= i_sample;
            b_q <= '0;
          end
          ACCUM: begin
            s2_q[b_q] <= s1_q[b_q];
            s1_q[b_q] <= s0;
            if (b_last) begin
              b_q <= '0;
              // n stays at N-1 through CALC/PRESENT; cleared after the last bin.
              if (!n_last) n_q <= n_q + NCW'(1);
            end else begin
              b_q <= b_q + AW'(1);
            end
          end
          CALC: begin
            re_q   <= calc_re;
            im_q   <= calc_im;
            bin_q  <= b_q;
            last_q <= b_last;
          end
          PRESENT: if (i_res_ready) begin
            if (b_last) begin
              n_q <= '0;
              b_q <= '0;
              for (int i = 0; i < NB; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
              end
            end else begin
              b_q <= b_q + AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GOERTZEL_MAG_EN
  logic [2*OW-1:0] re_sq, im_sq, mag_q;
  assign re_sq = {{OW{calc_re[OW-1]}}, calc_re} * {{OW{calc_re[OW-1]}}, calc_re};
  assign im_sq = {{OW{calc_im[OW-1]}}, calc_im} * {{OW{calc_im[OW-1]}}, calc_im};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              mag_q <= '0;
    else if (!i_clr && state_q == CALC) mag_q <= re_sq + im_sq;
  end
  assign o_res_mag = mag_q;
`else
  // Magnitude path not built.
`endif

  assign o_sample_ready = (state_q == IDLE);
  assign o_res_valid    = (state_q == PRESENT);
  assign o_res_bin      = bin_q;
  assign o_res_last     = last_q;
  assign o_res_re       = re_q;
  assign o_res_im       = im_q;
  assign o_coef_err     = coef_err_q;

endmodule

// File: tb/tb_goertzel_bank.sv
module tb_goertzel_bank;
  localparam int IW = 12, OW = 32, N = 6, NB = 2, CW = 16, AW = 1;

  logic          clk, rst_n, clr, s_vld, s_rdy;
  logic [IW-1:0] smp;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_cos, coef_sin;
  logic          coef_err;
  logic          res_vld, res_rdy;
  logic [AW-1:0] res_bin;
  logic          res_last;
  logic [OW-1:0] res_re, res_im;
`ifdef GOERTZEL_MAG_EN
  logic [2*OW-1:0] res_mag;
`endif

  goertzel_bank #(.IW(IW), .OW(OW), .N(N), .NB(NB), .CW(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
    .i_sample_valid(s_vld), .o_sample_ready(s_rdy), .i_sample(smp),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_cos(coef_cos),
    .i_coef_sin(coef_sin), .o_coef_err(coef_err),
    .o_res_valid(res_vld), .i_res_ready(res_rdy), .o_res_bin(res_bin),
    .o_res_last(res_last), .o_res_re(res_re), .o_res_im(res_im)
`ifdef GOERTZEL_MAG_EN
    , .o_res_mag(res_mag)
`endif
  );

  typedef struct {
    logic [AW-1:0]        bin;
    logic signed [OW-1:0] re;
    logic signed [OW-1:0] im;
    logic                 last;
    logic [2*OW-1:0]      mag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int bin, input int re, input int im, input bit last, input longint mag);
    exp_t e;
    e.bin = AW'(bin); e.re = re; e.im = im; e.last = last; e.mag = mag;
    exp_q.push_back(e);
  endtask

  task automatic push_imp();
    push(0, 1024, 0, 1'b0, 64'd1048576);
    push(1, 1024, 0, 1'b1, 64'd1048576);
  endtask

  task automatic push_dc();
    push(0, 0, 0, 1'b0, 64'd0);
    push(1, 6144, 0, 1'b1, 64'd37748736);
  endtask

  // Offers one sample and returns just after the edge that accepted it.
  task automatic send(input logic [IW-1:0] x);
    int t = 0;
    smp = x;
    s_vld = 1'b1;
    while (!s_rdy && t < 100) begin tick(); t++; end
    chk("send_ready", s_rdy, 1);
    tick();
    s_vld = 1'b0;
  endtask

  task automatic frame(input bit dc);
    for (int i = 0; i < N; i++) send((dc || i == 0) ? 12'd1024 : 12'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] c, input logic [CW-1:0] s);
    coef_we = 1'b1; coef_addr = a; coef_cos = c; coef_sin = s;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!res_vld && t < 100) begin tick(); t++; end
    chk("wait_valid", res_vld, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !s_rdy) && t < 200) begin tick(); t++; end
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  // Result monitor: compares every handshaked result against the queue head.
  always @(negedge clk) begin
    if (rst_n && res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_bin", res_bin, e.bin);
        chk("res_re", $signed(res_re), e.re);
        chk("res_im", $signed(res_im), e.im);
        chk("res_last", res_last, e.last);
`ifdef GOERTZEL_MAG_EN
        chk("res_mag", res_mag, e.mag);
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; s_vld = 1'b0; smp = '0;
    coef_we = 1'b0; coef_addr = '0; coef_cos = '0; coef_sin = '0; res_rdy = 1'b0;
    #1;
    chk("rst_sample_ready", s_rdy, 1);
    chk("rst_res_valid", res_vld, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_coef_err", coef_err, 0);
    chk("rst_res_bin", res_bin, 0);
    chk("rst_res_re", res_re, 0);
    chk("rst_res_im", res_im, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Coefficients: bin0 w=pi/3, bin1 DC.
    wr(0, 16'h2000, 16'h376D);
    chk("wr0_no_err", coef_err, 0);
    wr(1, 16'h4000, 16'h0000);
    chk("wr1_no_err", coef_err, 0);

    // Impulse frame with cycle-level latency checks.
    res_rdy = 1'b1;
    push_imp();
    send(12'd1024);
    tick(); chk("rdy_busy_accum", s_rdy, 0);
    tick(); chk("rdy_back_after_nb", s_rdy, 1);
    for (int i = 0; i < N - 2; i++) send(12'd0);
    send(12'd0);
    tick(); chk("lat_v0_k1", res_vld, 0);
    tick(); chk("lat_v0_k2", res_vld, 0);
    tick(); chk("lat_v1_k3", res_vld, 1);
    tick(); chk("bin1_calc_gap", res_vld, 0);
    tick(); chk("bin1_valid", res_vld, 1); chk("bin1_index", res_bin, 1);
    tick(); chk("rdy_after_last_hs", s_rdy, 1);
    drain();

    // DC frame.
    push_dc();
    frame(1'b1);
    drain();

    // Backpressure: hold bin0 result for 5 cycles.
    res_rdy = 1'b0;
    push_imp();
    frame(1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", res_vld, 1);
      chk("stall_re", res_re, 1024);
      chk("stall_im", res_im, 0);
      chk("stall_bin", res_bin, 0);
      chk("stall_sample_ready", s_rdy, 0);
    end
    res_rdy = 1'b1;
    drain();

    // Mid-frame coefficient write is rejected; old coefficients still apply.
    push_dc();
    send(12'd1024);
    wr(0, 16'h4000, 16'h0000);
    chk("midframe_coef_err", coef_err, 1);
    tick();
    chk("coef_err_one_pulse", coef_err, 0);
    for (int i = 0; i < N - 1; i++) send(12'd1024);
    drain();

    // Frame abort with a sample offered in the same cycle.
    send(12'd1024); send(12'd0); send(12'd0);
    begin
      int t = 0;
      while (!s_rdy && t < 100) begin tick(); t++; end
    end
    clr = 1'b1; s_vld = 1'b1; smp = 12'd777;
    tick();
    clr = 1'b0; s_vld = 1'b0;
    chk("clr_no_accept", s_rdy, 1);
    push_imp();
    frame(1'b0);
    drain();

    // Asynchronous reset while a result is presented.
    res_rdy = 1'b0;
    frame(1'b0);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res_valid", res_vld, 0);
    chk("arst_sample_ready", s_rdy, 1);
    chk("arst_res_re", res_re, 0);
    chk("arst_res_im", res_im, 0);
    chk("arst_res_bin", res_bin, 0);
    chk("arst_res_last", res_last, 0);
    chk("arst_coef_err", coef_err, 0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    res_rdy = 1'b1;
    // Cleared coefficients reduce the recurrence to s(n)=x-s(n-2).
    push(0, -1024, 0, 1'b0, 64'd1048576);
    push(1, -1024, 0, 1'b1, 64'd1048576);
    frame(1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/goertzel_bank.md
# goertzel_bank

Parametrised multi-bin Goertzel DFT engine and successor to the fixed-phase single-bin filter. It evaluates NB runtime-programmable frequency bins over N-sample frames. All bins share one multiplier, time-multiplexed across them. It sits between the decimated sample source and downstream spectral detection logic, using valid/ready handshakes on both the sample side and the result side.

## Interface
- IW, 12, input sample width, signed A(1,10)
- OW, 32, state and result width, signed
- N, 126, samples per frame (>=2)
- NB, 4, number of bins (>=1)
- CW, 16, coefficient width, signed, CW-2 fraction bits (range [-2,2))

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous frame abort
- i_sample_valid  in  1  sample offered
- o_sample_ready  out  1  sample accepted when valid&ready&!i_clr
- i_sample  in  IW  signed sample
- i_coef_we  in  1  coefficient write strobe
- i_coef_addr  in  max(1,$clog2(NB))  bin index
- i_coef_cos  in  CW  cos(w) for bin
- i_coef_sin  in  CW  sin(w) for bin
- o_coef_err  out  1  one-cycle pulse: write rejected
- o_res_valid  out  1  result presented
- i_res_ready  in  1  result consumed
- o_res_bin  out  max(1,$clog2(NB))  bin index of result
- o_res_last  out  1  high with bin NB-1
- o_res_re  out  OW  Re{X}
- o_res_im  out  OW  Im{X}

## Operation
- Per-bin state: s1[b]=s(n-1), s2[b]=s(n-2); coefficient regs cos[b], sin[b]; frame counter n (0..N-1).
- FSM states: IDLE, ACCUM, CALC, PRESENT.
- IDLE: o_sample_ready=1. On accept: latch sample, go to ACCUM with bin index b=0.
- ACCUM: one bin per cycle. s0 = x + ((cos[b]*s1[b])>>>(CW-3)) - s2[b]. The shift by CW-3 applies 2cos.
  - Then s2[b]<=s1[b], s1[b]<=s0.
  - After bin NB-1: if n==N-1 go to CALC (b=0), else n++ and return to IDLE.
- CALC (1 cycle) for bin b: re=((cos[b]*s1[b])>>>(CW-2)) - s2[b]; im=(sin[b]*s1[b])>>>(CW-2). Results are registered into the outputs. Go to PRESENT.
- PRESENT: o_res_valid=1, outputs held stable.
  - On i_res_ready: if b==NB-1, clear all s1/s2 and n, then go to IDLE.
  - Otherwise b++ and go to CALC.
- Arithmetic: products are OW+CW bits, arithmetic shift, truncated to OW. Two's-complement wrap, no saturation. Sample is sign-extended to OW.
- Coefficient write: accepted only in IDLE with n==0; takes effect the next cycle.
  - Otherwise the write is dropped and o_coef_err pulses the next cycle.
  - An address >=NB is dropped with o_coef_err.
- i_clr: highest synchronous priority. Goes to IDLE and zeros n, s1, s2, o_res_valid. Coefficients are kept. A sample offered in the same cycle is not accepted.

## Timing
- Reset (async, asserted): FSM=IDLE; n, s1, s2, all coefficients = 0. Outputs: o_sample_ready=1; o_res_valid, o_res_last, o_coef_err = 0; o_res_bin, o_res_re, o_res_im = 0.
- o_sample_ready is a decode of state==IDLE (combinational from registered state).
- Accept at edge k: ACCUM occupies edges k+1..k+NB; o_sample_ready high again after edge k+NB. Sustained throughput is 1 sample per NB+1 cycles.
- Last sample accepted at edge k: first o_res_valid after edge k+NB+1.
- With i_res_ready held high, each subsequent bin follows 2 cycles later (CALC+PRESENT). o_sample_ready rises the cycle after the last handshake.
- Reset mid-frame or mid-PRESENT: immediate return to reset values; any pending result is lost.

## Configuration
- GOERTZEL_MAG_EN defined: adds port o_res_mag out 2*OW = re*re+im*im (unsigned, computed from the truncated re/im). It is registered in CALC alongside re/im and resets to 0.
- Undefined: port and multiplier absent; all other behaviour identical.

## Test plan
- N=6, NB=2, bin0 cos=0x2000 sin=0x376D, bin1 cos=0x4000 sin=0. Impulse 1024,0,0,0,0,0 -> bin0 re=1024 im=0; bin1 re=1024 im=0, o_res_last=1; with MAG_EN, mag=1048576 both.
- Same config, DC input 1024 x6 -> bin0 re=0 im=0; bin1 re=6144 im=0.
- i_res_ready low for 5 cycles during bin0 PRESENT -> o_res_valid, o_res_re/o_res_im and o_res_bin stable; o_sample_ready=0 throughout.
- Coefficient write after 1 sample of frame -> o_coef_err single pulse, stored coefficient unchanged; results match the old coefficient.
- i_clr pulsed with i_sample_valid after 3 samples -> sample not accepted, next frame of impulse yields impulse results above.
- i_rst_n low during PRESENT -> o_res_valid=0 and all outputs/coefficients 0 without waiting for a clock edge.
